// File: rtl/fifo_prog.sv
// Synchronous FIFO with a programmable depth, almost-full/almost-empty thresholds,
// registered status pulses and a synchronous flush. Define FIFO_WATERMARK_EN to add a peak-occupancy output.
module fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH-1,
  parameter int AE_THRESH  = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [FIFO_WIDTH-1:0]               data_in,
  input  logic                                wr_en,
  input  logic                                rd_en,
  input  logic                                flush,
  output logic [FIFO_WIDTH-1:0]               data_out,
  output logic                                rd_valid,
  output logic                                wr_ack,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                full,
  output logic                                empty,
  output logic                                almostfull,
  output logic                                almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
`ifdef FIFO_WATERMARK_EN
  ,output logic [$clog2(FIFO_DEPTH+1)-1:0]    max_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, wr_ack_d, ovf_q, ovf_d, udf_q, udf_d, rdv_q, rdv_d;
  logic                  wr_acc, rd_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    // A full FIFO still takes a write when a read frees the slot on the same edge.
    wr_acc   = wr_en && (!full || rd_en);
    rd_acc   = rd_en && !empty;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    wr_ack_d = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    rdv_d    = 1'b0;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = ptr_inc(wptr_q);
      if (rd_acc) begin
        rptr_d = ptr_inc(rptr_q);
        dout_d = mem[rptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      wr_ack_d = wr_acc;
      ovf_d    = wr_en && !wr_acc;
      udf_d    = rd_en && !rd_acc;
      rdv_d    = rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem[wptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdv_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdv_q    <= rdv_d;
    end
  end

`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (flush)                max_d = '0;
    else if (count_d > max_q) max_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign max_count = max_q;
`endif

  assign data_out    = dout_q;
  assign rd_valid    = rdv_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  assign count       = count_q;
  assign almostfull  = (count_q >= CW'(AF_THRESH)) && !full;
  assign almostempty = (count_q != '0) && (count_q <= CW'(AE_THRESH));

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog at WIDTH=16, DEPTH=8, AF=6, AE=2.
module tb_fifo_prog;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, flush;
  logic [15:0] data_in, data_out;
  logic        rd_valid, wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [3:0]  count;
`ifdef FIFO_WATERMARK_EN
  logic [3:0]  max_count;
`endif

  int          total  = 0;
  int          passed = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_d, last_rd;

  always #5 clk = ~clk;

  fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_out(data_out), .rd_valid(rd_valid), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .count(count)
`ifdef FIFO_WATERMARK_EN
    , .max_count(max_count)
`endif
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; rd_en = 0; flush = 0; data_in = '0;
    tick(); tick();
    total++; if ({empty, full, almostfull, almostempty} !== 4'b1000) $display("FAIL reset_flags: got %b want 1000", {empty, full, almostfull, almostempty}); else passed++;
    total++; if (count !== 4'd0 || data_out !== 16'h0) $display("FAIL reset_count_data: got %0d/%h want 0/0000", count, data_out); else passed++;
    total++; if ({wr_ack, overflow, underflow, rd_valid} !== 4'b0000) $display("FAIL reset_pulses: got %b want 0000", {wr_ack, overflow, underflow, rd_valid}); else passed++;
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1; data_in = 16'(i); sb.push_back(16'(i));
      tick();
      total++; if (wr_ack !== 1'b1 || count !== 4'(i)) $display("FAIL fill_ack_count[%0d]: got %b/%0d want 1/%0d", i, wr_ack, count, i); else passed++;
      total++; if (almostfull !== (i >= 6 && i < 8) || full !== (i == 8)) $display("FAIL fill_af_full[%0d]: got %b%b want %b%b", i, almostfull, full, (i >= 6 && i < 8), (i == 8)); else passed++;
    end
    data_in = 16'h0009;
    tick();
    wr_en = 0;
    total++; if (overflow !== 1'b1 || wr_ack !== 1'b0 || count !== 4'd8) $display("FAIL fill_overflow: got ovf=%b ack=%b cnt=%0d want 1/0/8", overflow, wr_ack, count); else passed++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1;
      exp_d = sb.pop_front();
      tick();
      total++; if (rd_valid !== 1'b1 || data_out !== exp_d) $display("FAIL drain_data[%0d]: got %b/%h want 1/%h", i, rd_valid, data_out, exp_d); else passed++;
      total++; if (count !== 4'(8-i) || almostempty !== ((8-i) >= 1 && (8-i) <= 2) || empty !== (i == 8)) $display("FAIL drain_flags[%0d]: got cnt=%0d ae=%b e=%b", i, count, almostempty, empty); else passed++;
    end
    tick();
    rd_en = 0;
    total++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || data_out !== 16'h0008) $display("FAIL drain_underflow: got %b/%b/%h want 1/0/0008", underflow, rd_valid, data_out); else passed++;
  endtask

  task automatic test_simul();
    wr_en = 1; rd_en = 1; data_in = 16'hABCD; sb.push_back(16'hABCD);
    tick();
    rd_en = 0;
    total++; if (wr_ack !== 1'b1 || underflow !== 1'b1 || count !== 4'd1) $display("FAIL simul_empty: got ack=%b udf=%b cnt=%0d want 1/1/1", wr_ack, underflow, count); else passed++;
    for (int i = 0; i < 7; i++) begin
      data_in = 16'h0100 + 16'(i); sb.push_back(data_in);
      tick();
    end
    total++; if (full !== 1'b1) $display("FAIL simul_prefull: got %b want 1", full); else passed++;
    rd_en = 1; data_in = 16'h5555; sb.push_back(16'h5555);
    exp_d = sb.pop_front();
    tick();
    wr_en = 0; rd_en = 0;
    total++; if (wr_ack !== 1'b1 || overflow !== 1'b0 || count !== 4'd8) $display("FAIL simul_full: got ack=%b ovf=%b cnt=%0d want 1/0/8", wr_ack, overflow, count); else passed++;
    total++; if (rd_valid !== 1'b1 || data_out !== exp_d) $display("FAIL simul_full_data: got %b/%h want 1/%h", rd_valid, data_out, exp_d); else passed++;
    rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      exp_d = sb.pop_front();
      tick();
      total++; if (data_out !== exp_d) $display("FAIL simul_drain[%0d]: got %h want %h", i, data_out, exp_d); else passed++;
    end
    rd_en = 0;
    last_rd = exp_d;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        wr_en = 1; rd_en = 0; data_in = 16'h0200 + 16'(i); sb.push_back(data_in);
        tick();
        total++; if (count !== 4'd1 || wr_ack !== 1'b1) $display("FAIL wrap_wr[%0d]: got cnt=%0d ack=%b want 1/1", i, count, wr_ack); else passed++;
      end else begin
        wr_en = 0; rd_en = 1; exp_d = sb.pop_front();
        tick();
        total++; if (count !== 4'd0 || rd_valid !== 1'b1 || data_out !== exp_d) $display("FAIL wrap_rd[%0d]: got cnt=%0d v=%b d=%h want 0/1/%h", i, count, rd_valid, data_out, exp_d); else passed++;
        last_rd = exp_d;
      end
    end
    wr_en = 0; rd_en = 0;
  endtask

  task automatic test_flush();
    flush = 1; tick(); flush = 0;
    wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h0300 + 16'(i); tick();
    end
    wr_en = 0;
    total++; if (count !== 4'd5) $display("FAIL flush_pre_count: got %0d want 5", count); else passed++;
`ifdef FIFO_WATERMARK_EN
    total++; if (max_count !== 4'd5) $display("FAIL flush_pre_max: got %0d want 5", max_count); else passed++;
`endif
    flush = 1; wr_en = 1; data_in = 16'hDEAD;
    tick();
    flush = 0; wr_en = 0;
    total++; if (count !== 4'd0 || empty !== 1'b1 || wr_ack !== 1'b0) $display("FAIL flush: got cnt=%0d e=%b ack=%b want 0/1/0", count, empty, wr_ack); else passed++;
    total++; if (data_out !== last_rd) $display("FAIL flush_hold: got %h want %h", data_out, last_rd); else passed++;
`ifdef FIFO_WATERMARK_EN
    total++; if (max_count !== 4'd0) $display("FAIL flush_max: got %0d want 0", max_count); else passed++;
`endif
    sb.delete();
  endtask

  task automatic test_async_reset();
    wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      data_in = 16'h0400 + 16'(i); tick();
    end
    total++; if (count !== 4'd3) $display("FAIL areset_pre: got %0d want 3", count); else passed++;
    @(negedge clk); #1 rst = 1'b1;
    #1;
    total++; if (empty !== 1'b1 || count !== 4'd0 || data_out !== 16'h0) $display("FAIL areset_state: got e=%b cnt=%0d d=%h want 1/0/0000", empty, count, data_out); else passed++;
    total++; if ({wr_ack, overflow, underflow, rd_valid} !== 4'b0000) $display("FAIL areset_pulses: got %b want 0000", {wr_ack, overflow, underflow, rd_valid}); else passed++;
    wr_en = 0;
    tick();
    @(negedge clk); rst = 1'b0;
    wr_en = 1; data_in = 16'h0077;
    tick();
    wr_en = 0; rd_en = 1;
    total++; if (wr_ack !== 1'b1 || count !== 4'd1) $display("FAIL areset_first_wr: got ack=%b cnt=%0d want 1/1", wr_ack, count); else passed++;
    tick();
    rd_en = 0;
    total++; if (rd_valid !== 1'b1 || data_out !== 16'h0077) $display("FAIL areset_first_rd: got %b/%h want 1/0077", rd_valid, data_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
